// File: rtl/if_id_stage_buffer_pkg.sv
// Shared definitions for the IF/ID skid buffer: state encodings and datapath defaults.
package if_id_stage_buffer_pkg;

  localparam int          DATA_W_DEF    = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFID_EMPTY = 2'b00,
    IFID_ONE   = 2'b01,
    IFID_TWO   = 2'b10
  } ifid_state_e;

endpackage

// File: rtl/if_id_stage_buffer_entry.sv
// One held fetch entry {pc, npc, instr}: load-enabled register with synchronous active-low reset.
module if_id_stage_buffer_entry #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RST_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d_pc,
  input  logic [DATA_W-1:0] d_npc,
  input  logic [DATA_W-1:0] d_instr,
  output logic [DATA_W-1:0] q_pc,
  output logic [DATA_W-1:0] q_npc,
  output logic [DATA_W-1:0] q_instr
);

  // payload register; contents only change on an explicit load
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_pc    <= '0;
      q_npc   <= '0;
      q_instr <= RST_INSTR;
    end else if (load) begin
      q_pc    <= d_pc;
      q_npc   <= d_npc;
      q_instr <= d_instr;
    end else begin
      q_pc    <= q_pc;
      q_npc   <= q_npc;
      q_instr <= q_instr;
    end
  end

endmodule

// File: rtl/if_id_stage_buffer.sv
// Fetch-to-decode 2-entry skid buffer with flush. Optional IF_ID_PERF_EN adds stall/flush counters.
module if_id_stage_buffer
  import if_id_stage_buffer_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [DATA_W-1:0] if_pc,
  input  logic [DATA_W-1:0] if_npc,
  input  logic [DATA_W-1:0] if_instr,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_npc,
`ifdef IF_ID_PERF_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic [DATA_W-1:0] id_instr
);

  ifid_state_e       state_r, next_state_s;
  logic              in_s, out_s;
  logic              head_load_s, skid_load_s;
  logic [DATA_W-1:0] head_pc_s, head_npc_s, head_instr_s;
  logic [DATA_W-1:0] skid_pc_s, skid_npc_s, skid_instr_s;
  logic [DATA_W-1:0] head_d_pc_s, head_d_npc_s, head_d_instr_s;

  assign in_s  = if_valid & if_ready;
  assign out_s = id_valid & id_ready;

  // state register plus handshake flags, both taken from the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IFID_EMPTY;
      if_ready <= 1'b1;
      id_valid <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      if_ready <= (next_state_s != IFID_TWO);
      id_valid <= (next_state_s != IFID_EMPTY);
    end
  end

  // occupancy transitions; flush wins over any transfer
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = IFID_EMPTY;
    end else begin
      case (state_r)
        IFID_EMPTY: next_state_s = in_s ? IFID_ONE : IFID_EMPTY;
        IFID_ONE: begin
          if (in_s && !out_s)      next_state_s = IFID_TWO;
          else if (!in_s && out_s) next_state_s = IFID_EMPTY;
          else                     next_state_s = IFID_ONE;
        end
        IFID_TWO:   next_state_s = out_s ? IFID_ONE : IFID_TWO;
        default:    next_state_s = IFID_EMPTY;
      endcase
    end
  end

  // entry load enables; in TWO the head refills from the skid instead of fetch
  always_comb begin
    head_load_s = 1'b0;
    skid_load_s = 1'b0;
    if (flush) begin
      head_load_s = 1'b0;
      skid_load_s = 1'b0;
    end else begin
      case (state_r)
        IFID_EMPTY: head_load_s = in_s;
        IFID_ONE: begin
          head_load_s = in_s & out_s;
          skid_load_s = in_s & ~out_s;
        end
        IFID_TWO:   head_load_s = out_s;
        default: begin
          head_load_s = 1'b0;
          skid_load_s = 1'b0;
        end
      endcase
    end
  end

  assign head_d_pc_s    = (state_r == IFID_TWO) ? skid_pc_s    : if_pc;
  assign head_d_npc_s   = (state_r == IFID_TWO) ? skid_npc_s   : if_npc;
  assign head_d_instr_s = (state_r == IFID_TWO) ? skid_instr_s : if_instr;

  if_id_stage_buffer_entry #(.DATA_W(DATA_W), .RST_INSTR(NOP_INSTR)) u_head (
    .clk(clk), .rst(rst), .load(head_load_s),
    .d_pc(head_d_pc_s), .d_npc(head_d_npc_s), .d_instr(head_d_instr_s),
    .q_pc(head_pc_s), .q_npc(head_npc_s), .q_instr(head_instr_s)
  );

  if_id_stage_buffer_entry #(.DATA_W(DATA_W), .RST_INSTR(NOP_INSTR)) u_skid (
    .clk(clk), .rst(rst), .load(skid_load_s),
    .d_pc(if_pc), .d_npc(if_npc), .d_instr(if_instr),
    .q_pc(skid_pc_s), .q_npc(skid_npc_s), .q_instr(skid_instr_s)
  );

  assign id_pc    = head_pc_s;
  assign id_npc   = head_npc_s;
  assign id_instr = id_valid ? head_instr_s : NOP_INSTR;

`ifdef IF_ID_PERF_EN
  // saturating counters: decode stalls and flushes that actually killed an entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (id_valid && !id_ready && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      else                                                       stall_cnt <= stall_cnt;
      if (flush && (state_r != IFID_EMPTY) && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
      else                                                                  flush_cnt <= flush_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Directed table-driven bench for if_id_stage_buffer, plus hand sequences for reset and counters.
module tb_if_id_stage_buffer;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, id_ready;
  logic        if_ready, id_valid;
  logic [31:0] if_pc, if_npc, if_instr, id_pc, id_npc, id_instr;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  if_id_stage_buffer dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_npc(if_npc), .if_instr(if_instr),
    .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_npc(id_npc),
`ifdef IF_ID_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .id_instr(id_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fl;
    logic        rdy;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                     input logic fl, input logic rdy, input logic e_valid, input logic e_ready,
                     input logic [31:0] e_pc, input logic [31:0] e_npc, input logic [31:0] e_instr);
    vec_t t;
    t.v = v; t.pc = pc; t.instr = instr; t.fl = fl; t.rdy = rdy;
    t.e_valid = e_valid; t.e_ready = e_ready; t.e_pc = e_pc; t.e_npc = e_npc; t.e_instr = e_instr;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic fl, input logic rdy);
    if_valid = v; if_pc = pc; if_npc = pc + 32'd4; if_instr = instr; flush = fl; id_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic ev, input logic er,
                            input logic [31:0] ep, input logic [31:0] en, input logic [31:0] ei);
    check({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, ev});
    check({tag, ".if_ready"}, {31'd0, if_ready}, {31'd0, er});
    check({tag, ".id_pc"},    id_pc,    ep);
    check({tag, ".id_npc"},   id_npc,   en);
    check({tag, ".id_instr"}, id_instr, ei);
  endtask

  initial begin
    // T2 streaming: each entry visible after its own edge, no bubbles
    for (int i = 0; i < 8; i++)
      add(1'b1, 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b1,
          1'b1, 1'b1, 32'(4 * i), 32'(4 * i + 4), 32'hA000_0000 + 32'(i));
    add(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1C, 32'h20, NOP);
    // T3 back-pressure into TWO, then drain in order
    add(1'b1, 32'h100, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h104, 32'h1111_1111);
    add(1'b1, 32'h104, 32'h2222_2222, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h104, 32'h1111_1111);
    add(1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h104, 32'h1111_1111);
    add(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h108, 32'h2222_2222);
    add(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h104, 32'h108, NOP);
    // T4 flush while TWO with a same-cycle offer
    add(1'b1, 32'h300, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h304, 32'h3333_3333);
    add(1'b1, 32'h304, 32'h4444_4444, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h304, 32'h3333_3333);
    add(1'b1, 32'h308, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h304, NOP);
    add(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h304, NOP);
    // T5 simultaneous in and out while ONE
    add(1'b1, 32'h400, 32'hAAAA_0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 32'h404, 32'hAAAA_0000);
    add(1'b1, 32'h404, 32'hBBBB_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h404, 32'h408, 32'hBBBB_0000);
    add(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h404, 32'h408, NOP);
    // flush while EMPTY discards the offer
    add(1'b1, 32'h500, 32'h6666_6666, 1'b1, 1'b1, 1'b0, 1'b1, 32'h404, 32'h408, NOP);
    add(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h404, 32'h408, NOP);

    // T1 reset held two cycles with fetch offering
    rst = 1'b0;
    drive(1'b1, 32'h700, 32'h7777_7777, 1'b0, 1'b1);
    step();
    step();
    check_outs("reset", 1'b0, 1'b1, 32'h0, 32'h0, NOP);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].pc, vecs[k].instr, vecs[k].fl, vecs[k].rdy);
      step();
      check_outs($sformatf("vec%0d", k), vecs[k].e_valid, vecs[k].e_ready,
                 vecs[k].e_pc, vecs[k].e_npc, vecs[k].e_instr);
    end

    // reset mid-operation while TWO drops both entries
    drive(1'b1, 32'h800, 32'h8888_0000, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h804, 32'h8888_0004, 1'b0, 1'b0);
    step();
    check_outs("fill_two", 1'b1, 1'b0, 32'h800, 32'h804, 32'h8888_0000);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    check_outs("mid_reset", 1'b0, 1'b1, 32'h0, 32'h0, NOP);
    rst = 1'b1;
    step();
    check_outs("after_reset", 1'b0, 1'b1, 32'h0, 32'h0, NOP);

`ifdef IF_ID_PERF_EN
    // T6: 5 stalls, one effective flush, one flush while EMPTY
    rst = 1'b0;
    step();
    rst = 1'b1;
    drive(1'b1, 32'h900, 32'h9999_0000, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int s = 0; s < 5; s++) step();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    check("stall_cnt", stall_cnt, 32'd5);
    check("flush_cnt", flush_cnt, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
